// File: rtl/daq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : daq_pkg
//  Description : Shared constants and state encodings for the ADC frame
//                writer (capture FSM, memory writer FSM).
//  Revision    : 1.0 - initial release
// ============================================================================
package daq_pkg;

    localparam int DAQ_ADDR_W     = 26;
    localparam int DAQ_DATA_W     = 32;
    localparam int DAQ_SAMPLE_W   = 14;
    localparam int DAQ_LEN_W      = 16;
    localparam int DAQ_FIFO_DEPTH = 16;

    // Capture sequencing: idle, taking samples, waiting for the FIFO to drain,
    // and a single-cycle done state.
    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_CAPTURE = 2'd1,
        CAP_DRAIN   = 2'd2,
        CAP_DONE    = 2'd3
    } cap_state_t;

    // Memory writer: pop a word, hold the request until accepted, then one
    // gap cycle so hal can raise busy before the next request.
    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_REQ  = 2'd1,
        WR_GAP  = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO with full/empty flags and a
//                synchronous flush. A push while full is rejected even if a
//                pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointer update; the extra MSB distinguishes full from empty.
    always_comb begin
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        push_ok  = push && !full && !flush;
        pop_ok   = pop && !empty && !flush;
        pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_frame_writer
//  Description : Packs 14-bit ADC samples pairwise into 32-bit words and
//                writes a host-programmed number of words to DDR through the
//                hal memory-request port, buffering stalls in a small FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_writer
    import daq_pkg::*;
#(
    parameter int ADDR_W     = DAQ_ADDR_W,
    parameter int DATA_W     = DAQ_DATA_W,
    parameter int SAMPLE_W   = DAQ_SAMPLE_W,
    parameter int LEN_W      = DAQ_LEN_W,
    parameter int FIFO_DEPTH = DAQ_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic              sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic              active,
    output logic              done,
    output logic              overflow,
    output logic [LEN_W-1:0]  words_written,
    output logic              memory_write_req,
    output logic [ADDR_W-1:0] memory_addr,
    output logic [DATA_W-1:0] memory_data_write,
    input  logic              memory_busy
);
    localparam int HALF_W = 16;

    cap_state_t        cap_state_q, cap_state_d;
    wr_state_t         wr_state_q, wr_state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LEN_W-1:0]  length_q, length_d;
    logic [LEN_W-1:0]  packed_q, packed_d;
    logic [LEN_W-1:0]  words_written_q, words_written_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic              half_valid_q, half_valid_d;
    logic              overflow_q, overflow_d;

    logic              start_take;
    logic              sample_take;
    logic              word_push;
    logic              wr_accept;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [HALF_W-1:0] sample_ext;
    logic [DATA_W-1:0] packed_word;
    logic [DATA_W-1:0] fifo_rd_data;

    // Packed-word buffer; abort flushes it along with the pending half-word.
    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (abort),
        .push      (word_push),
        .push_data (packed_word),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_state_q     <= CAP_IDLE;
            wr_state_q      <= WR_IDLE;
            addr_q          <= '0;
            data_q          <= '0;
            length_q        <= '0;
            packed_q        <= '0;
            words_written_q <= '0;
            half_q          <= '0;
            half_valid_q    <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            cap_state_q     <= cap_state_d;
            wr_state_q      <= wr_state_d;
            addr_q          <= addr_d;
            data_q          <= data_d;
            length_q        <= length_d;
            packed_q        <= packed_d;
            words_written_q <= words_written_d;
            half_q          <= half_d;
            half_valid_q    <= half_valid_d;
            overflow_q      <= overflow_d;
        end
    end

    // Capture FSM next state; abort overrides everything, start only from idle.
    always_comb begin
        cap_state_d = cap_state_q;
        if (abort) begin
            cap_state_d = CAP_IDLE;
        end else begin
            case (cap_state_q)
                CAP_IDLE: begin
                    if (start) begin
                        cap_state_d = (length == '0) ? CAP_DONE : CAP_CAPTURE;
                    end
                end
                CAP_CAPTURE: begin
                    if (packed_q == length_q) begin
                        cap_state_d = CAP_DRAIN;
                    end
                end
                CAP_DRAIN: begin
                    if (fifo_empty && (wr_state_q == WR_IDLE)) begin
                        cap_state_d = CAP_DONE;
                    end
                end
                CAP_DONE: cap_state_d = CAP_IDLE;
                default:  cap_state_d = CAP_IDLE;
            endcase
        end
    end

    // Writer FSM next state; the request is held until hal drops busy.
    always_comb begin
        wr_state_d = wr_state_q;
        if (abort) begin
            wr_state_d = WR_IDLE;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (!fifo_empty) begin
                        wr_state_d = WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (!memory_busy) begin
                        wr_state_d = WR_GAP;
                    end
                end
                WR_GAP:  wr_state_d = WR_IDLE;
                default: wr_state_d = WR_IDLE;
            endcase
        end
    end

    // Packer, counters, address and write-data staging.
    always_comb begin
        start_take  = start && !abort && (cap_state_q == CAP_IDLE);
        sample_take = sample_valid && !abort && (cap_state_q == CAP_CAPTURE) &&
                      (packed_q != length_q);
        word_push   = sample_take && half_valid_q;
        wr_accept   = (wr_state_q == WR_REQ) && !memory_busy && !abort;
        fifo_pop    = (wr_state_q == WR_IDLE) && !fifo_empty && !abort;
        sample_ext  = {{(HALF_W-SAMPLE_W){1'b0}}, sample_data};
        packed_word = DATA_W'({sample_ext, half_q});

        length_d        = length_q;
        packed_d        = packed_q;
        words_written_d = words_written_q;
        overflow_d      = overflow_q;
        half_d          = half_q;
        half_valid_d    = half_valid_q;
        addr_d          = addr_q;
        data_d          = data_q;

        if (start_take) begin
            length_d        = length;
            addr_d          = base_addr;
            packed_d        = '0;
            words_written_d = '0;
            overflow_d      = 1'b0;
            half_valid_d    = 1'b0;
        end
        if (abort) begin
            half_valid_d = 1'b0;
        end
        if (sample_take) begin
            if (!half_valid_q) begin
                half_d       = sample_ext;
                half_valid_d = 1'b1;
            end else begin
                // Word completes on the odd sample; a dropped word still counts.
                half_valid_d = 1'b0;
                packed_d     = packed_q + LEN_W'(1);
                if (fifo_full) begin
                    overflow_d = 1'b1;
                end
            end
        end
        if (fifo_pop) begin
            data_d = fifo_rd_data;
        end
        if (wr_accept) begin
            addr_d          = addr_q + ADDR_W'(1);
            words_written_d = words_written_q + LEN_W'(1);
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        active            = (cap_state_q == CAP_CAPTURE) || (cap_state_q == CAP_DRAIN);
        done              = (cap_state_q == CAP_DONE);
        memory_write_req  = (wr_state_q == WR_REQ);
        overflow          = overflow_q;
        words_written     = words_written_q;
        memory_addr       = addr_q;
        memory_data_write = data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_frame_writer
//  Description : Self-checking bench for adc_frame_writer: directed scenarios
//                plus randomized captures scored against a queue of expected
//                memory writes built from the packing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_frame_writer;
    localparam int ADDR_W   = 26;
    localparam int DATA_W   = 32;
    localparam int SAMPLE_W = 14;
    localparam int LEN_W    = 16;
    localparam int DEPTH    = 4;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [ADDR_W-1:0]   base_addr = '0;
    logic [LEN_W-1:0]    length = '0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_data = '0;
    logic                memory_busy = 1'b0;
    logic                active;
    logic                done;
    logic                overflow;
    logic [LEN_W-1:0]    words_written;
    logic                memory_write_req;
    logic [ADDR_W-1:0]   memory_addr;
    logic [DATA_W-1:0]   memory_data_write;

    adc_frame_writer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SAMPLE_W   (SAMPLE_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .abort             (abort),
        .base_addr         (base_addr),
        .length            (length),
        .sample_valid      (sample_valid),
        .sample_data       (sample_data),
        .active            (active),
        .done              (done),
        .overflow          (overflow),
        .words_written     (words_written),
        .memory_write_req  (memory_write_req),
        .memory_addr       (memory_addr),
        .memory_data_write (memory_data_write),
        .memory_busy       (memory_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t                 exp_q[$];
    logic [SAMPLE_W-1:0] smp [20];
    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int writes_seen, done_seen, req_cycles, active_seen, first_req_cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [DATA_W-1:0] pack(input logic [SAMPLE_W-1:0] lo,
                                               input logic [SAMPLE_W-1:0] hi);
        return {2'b00, hi, 2'b00, lo};
    endfunction

    task automatic clear_mon();
        writes_seen   = 0;
        done_seen     = 0;
        req_cycles    = 0;
        active_seen   = 0;
        first_req_cyc = -1;
    endtask

    // One clock cycle: observe outputs mid-low-phase, score any accepted write.
    task automatic step();
        #1;
        if (active) active_seen++;
        if (done) done_seen++;
        if (memory_write_req) begin
            req_cycles++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            if (!memory_busy) begin
                writes_seen++;
                check("wr_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    wr_t e = exp_q.pop_front();
                    check("wr_addr", 64'(memory_addr), 64'(e.addr));
                    check("wr_data", 64'(memory_data_write), 64'(e.data));
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] n);
        base_addr    = b;
        length       = n;
        start        = 1'b1;
        sample_valid = 1'b1;
        sample_data  = SAMPLE_W'($urandom);
        step();
        start        = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic fill_samples(input int n);
        for (int i = 0; i < n; i++) smp[i] = SAMPLE_W'($urandom);
    endtask

    task automatic feed_samples(input int n);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_data  = smp[i];
            step();
        end
        sample_valid = 1'b0;
    endtask

    task automatic expect_words(input logic [ADDR_W-1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            wr_t e;
            e.addr = b + ADDR_W'(i);
            e.data = pack(smp[2*i], smp[2*i+1]);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_seen == 0; i++) step();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_active"}, 64'(active), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_overflow"}, 64'(overflow), 64'(0));
        check({tag, "_ww"}, 64'(words_written), 64'(0));
        check({tag, "_req"}, 64'(memory_write_req), 64'(0));
        check({tag, "_addr"}, 64'(memory_addr), 64'(0));
        check({tag, "_data"}, 64'(memory_data_write), 64'(0));
    endtask

    initial begin
        int s, stable;
        logic [ADDR_W-1:0] held_a;
        logic [DATA_W-1:0] held_d;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Basic two-word capture with latency check
        clear_mon();
        exp_q.push_back('{addr: 26'h100, data: 32'h0002_0001});
        exp_q.push_back('{addr: 26'h101, data: 32'h0004_0003});
        smp[0] = 14'd1; smp[1] = 14'd2; smp[2] = 14'd3; smp[3] = 14'd4;
        s = cyc;
        do_start(26'h100, 16'd2);
        feed_samples(4);
        wait_done(60);
        check("t1_latency", 64'(first_req_cyc), 64'(s + 4));
        check("t1_done", 64'(done_seen), 64'(1));
        check("t1_writes", 64'(writes_seen), 64'(2));
        check("t1_ww", 64'(words_written), 64'(2));
        check("t1_pending", 64'(exp_q.size()), 64'(0));
        check("t1_active_seen", 64'(active_seen != 0), 64'(1));
        check("t1_active_after", 64'(active), 64'(0));

        // Request held stable for ten busy cycles
        clear_mon();
        smp[0] = 14'd5; smp[1] = 14'd6;
        exp_q.push_back('{addr: 26'h200, data: 32'h0006_0005});
        do_start(26'h200, 16'd1);
        memory_busy = 1'b1;
        feed_samples(2);
        for (int i = 0; i < 20 && req_cycles == 0; i++) step();
        held_a = memory_addr;
        held_d = memory_data_write;
        stable = 0;
        for (int i = 0; i < 9; i++) begin
            if (memory_write_req && memory_addr == held_a && memory_data_write == held_d) stable++;
            step();
        end
        check("t2_stable", 64'(stable), 64'(9));
        check("t2_held_addr", 64'(held_a), 64'(26'h200));
        check("t2_no_write_yet", 64'(writes_seen), 64'(0));
        memory_busy = 1'b0;
        wait_done(40);
        check("t2_req_cycles", 64'(req_cycles), 64'(11));
        check("t2_writes", 64'(writes_seen), 64'(1));
        check("t2_ww", 64'(words_written), 64'(1));
        check("t2_done", 64'(done_seen), 64'(1));

        // Zero-length capture
        clear_mon();
        do_start(26'h300, 16'd0);
        step();
        check("t3_done_next", 64'(done_seen), 64'(1));
        repeat (4) step();
        check("t3_done_once", 64'(done_seen), 64'(1));
        check("t3_no_req", 64'(req_cycles), 64'(0));
        check("t3_no_active", 64'(active_seen), 64'(0));
        check("t3_ww", 64'(words_written), 64'(0));

        // Overflow with a stalled memory port
        clear_mon();
        memory_busy = 1'b1;
        fill_samples(20);
        expect_words(26'h400, DEPTH + 1);
        s = cyc;
        do_start(26'h400, 16'd10);
        feed_samples(20);
        while (cyc - s < 100) step();
        memory_busy = 1'b0;
        wait_done(200);
        check("t4_overflow", 64'(overflow), 64'(1));
        check("t4_ww", 64'(words_written), 64'(5));
        check("t4_writes", 64'(writes_seen), 64'(5));
        check("t4_pending", 64'(exp_q.size()), 64'(0));
        check("t4_done", 64'(done_seen), 64'(1));
        repeat (3) step();
        check("t4_overflow_sticky", 64'(overflow), 64'(1));

        // Address wrap at the top of the address space
        clear_mon();
        fill_samples(4);
        expect_words(26'h3FF_FFFF, 2);
        do_start(26'h3FF_FFFF, 16'd2);
        check("t5_overflow_cleared", 64'(overflow), 64'(0));
        feed_samples(4);
        wait_done(60);
        check("t5_writes", 64'(writes_seen), 64'(2));
        check("t5_pending", 64'(exp_q.size()), 64'(0));
        check("t5_addr_after", 64'(memory_addr), 64'(26'h000_0001));

        // Abort after three words
        clear_mon();
        fill_samples(16);
        expect_words(26'h500, 4);
        do_start(26'h500, 16'd8);
        for (int i = 0; i < 60 && writes_seen < 3; i++) begin
            sample_valid = (i < 8);
            sample_data  = smp[i % 16];
            step();
        end
        sample_valid = 1'b0;
        memory_busy  = 1'b1;
        abort        = 1'b1;
        step();
        abort        = 1'b0;
        check("t6_abort_req", 64'(memory_write_req), 64'(0));
        check("t6_abort_active", 64'(active), 64'(0));
        memory_busy = 1'b0;
        repeat (6) step();
        check("t6_abort_ww", 64'(words_written), 64'(3));
        check("t6_abort_writes", 64'(writes_seen), 64'(3));
        check("t6_abort_no_done", 64'(done_seen), 64'(0));
        exp_q.delete();

        // Asynchronous reset while a request is pending
        clear_mon();
        fill_samples(2);
        expect_words(26'h600, 1);
        do_start(26'h600, 16'd1);
        memory_busy = 1'b1;
        feed_samples(2);
        for (int i = 0; i < 20 && req_cycles == 0; i++) step();
        check("t6_req_before_reset", 64'(memory_write_req), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t6_reset");
        exp_q.delete();
        @(negedge clk);
        reset_n     = 1'b1;
        memory_busy = 1'b0;
        step();

        // Normal capture after reset
        clear_mon();
        fill_samples(2);
        expect_words(26'h700, 1);
        do_start(26'h700, 16'd1);
        feed_samples(2);
        wait_done(40);
        check("t6_post_writes", 64'(writes_seen), 64'(1));
        check("t6_post_ww", 64'(words_written), 64'(1));
        check("t6_post_done", 64'(done_seen), 64'(1));

        // Randomized captures short enough never to overflow
        for (int r = 0; r < 8; r++) begin
            int n, idx;
            logic [ADDR_W-1:0] b;
            n = $urandom_range(1, DEPTH + 1);
            b = (r == 0) ? 26'h3FF_FFFE : ADDR_W'($urandom);
            fill_samples(2 * n);
            clear_mon();
            memory_busy = 1'b0;
            expect_words(b, n);
            do_start(b, LEN_W'(n));
            idx = 0;
            for (int k = 0; k < 400 && done_seen == 0; k++) begin
                sample_valid = ($urandom_range(0, 1) == 1);
                sample_data  = (idx < 2 * n) ? smp[idx] : SAMPLE_W'($urandom);
                memory_busy  = ($urandom_range(0, 2) == 0);
                step();
                if (sample_valid && idx < 2 * n) idx++;
            end
            sample_valid = 1'b0;
            memory_busy  = 1'b0;
            check("rnd_done", 64'(done_seen), 64'(1));
            check("rnd_ww", 64'(words_written), 64'(n));
            check("rnd_pending", 64'(exp_q.size()), 64'(0));
            check("rnd_overflow", 64'(overflow), 64'(0));
            exp_q.delete();
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
